matmul_seq_ctrl: RTL and testbench

Sequencer for the fixed-point complex matrix multiplier. Accepts a word stream holding matrices A and B (real plane, then imaginary plane, each row-major), writes it into the four Q_RAM planes via `we`/`Dir_M1`/`Dir_M2`, then steps the read addresses over every (row, column) pair of the product. It counts results returned by the multiply datapath and signals completion. It sits between the host-side loader and Q_RAM / Mem_Manager-driven datapath, replacing ad-hoc bench sequencing.

---
 rtl/matmul_seq_ctrl_pkg.sv | 36 +++
 rtl/matmul_seq_ctrl_if.sv | 31 +++
 rtl/matmul_seq_ctrl_idx_counter.sv | 37 +++
 rtl/matmul_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_seq_ctrl_pkg.sv
// Shared types and constants for the complex matrix multiplier sequencer.
package fxp_mat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_DRAIN
    } seq_state_t;

    // Q_RAM plane write enables, indexed by load plane order below
    localparam logic [3:0] WE_A_RE = 4'b0001;
    localparam logic [3:0] WE_A_IM = 4'b0100;
    localparam logic [3:0] WE_B_RE = 4'b0010;
    localparam logic [3:0] WE_B_IM = 4'b1000;

    localparam int unsigned N_PLANES           = 4;
    localparam int unsigned MATRIX_DIM_DEFAULT = 8;
    localparam int unsigned MAT_WORDS          = MATRIX_DIM_DEFAULT * MATRIX_DIM_DEFAULT;

    // Load plane order: A-real, A-imag, B-real, B-imag
    function automatic logic [3:0] plane_we(input logic [1:0] plane);
        case (plane)
            2'd0:    return WE_A_RE;
            2'd1:    return WE_A_IM;
            2'd2:    return WE_B_RE;
            default: return WE_B_IM;
        endcase
    endfunction

    // Counter width able to hold values 0..n-1 (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Stream, Q_RAM and datapath-facing signals of the sequencer.
interface matmul_seq_ctrl_if #(
    parameter int unsigned WORD_LEN  = 16,
    parameter int unsigned ADDR_BITS = 7
);
    logic                 start;
    logic                 s_valid;
    logic                 s_ready;
    logic [WORD_LEN-1:0]  s_data;
    logic [3:0]           we;
    logic [WORD_LEN-1:0]  wr_data;
    logic [ADDR_BITS-1:0] Dir_M1;
    logic [ADDR_BITS-1:0] Dir_M2;
    logic                 rd_valid;
    logic                 res_valid;
    logic                 busy;
    logic                 done;
    logic                 err;

    // Sequencer side
    modport master (
        input  start, s_valid, s_data, res_valid,
        output s_ready, we, wr_data, Dir_M1, Dir_M2, rd_valid, busy, done, err
    );

    // Host loader / datapath side
    modport slave (
        output start, s_valid, s_data, res_valid,
        input  s_ready, we, wr_data, Dir_M1, Dir_M2, rd_valid, busy, done, err
    );
endinterface

// File: rtl/matmul_seq_ctrl_idx_counter.sv
// Two-level (outer, inner) index counter; inner runs fastest, wraps to 0 after last.
module mat_idx_counter
    import fxp_mat_pkg::*;
#(
    parameter int unsigned OUTER_N = 4,
    parameter int unsigned INNER_N = 64,
    parameter int unsigned OUTER_W = cnt_width(OUTER_N),
    parameter int unsigned INNER_W = cnt_width(INNER_N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    output logic [OUTER_W-1:0] outer,
    output logic [INNER_W-1:0] inner,
    output logic               last
);
    logic inner_wrap;

    assign inner_wrap = (inner == INNER_W'(INNER_N - 1));
    assign last       = inner_wrap && (outer == OUTER_W'(OUTER_N - 1));

    // Advance inner each enabled cycle, carry into outer on inner wrap
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            outer <= '0;
            inner <= '0;
        end else if (en) begin
            if (inner_wrap) begin
                inner <= '0;
                outer <= last ? '0 : outer + OUTER_W'(1);
            end else begin
                inner <= inner + INNER_W'(1);
            end
        end
    end
endmodule

// File: rtl/matmul_seq_ctrl.sv
// Load / compute / drain sequencer for the fixed-point complex matrix multiplier.
module matmul_seq_ctrl
    import fxp_mat_pkg::*;
#(
    parameter int unsigned WORD_LEN    = 16,
    parameter int unsigned MATRIX_DIM  = 8,
    parameter int unsigned ADDR_BITS   = 7,
    parameter int unsigned RES_TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst,
    matmul_seq_ctrl_if.master bus
);
    localparam int unsigned N_WORDS = MATRIX_DIM * MATRIX_DIM;
    localparam int unsigned PL_W    = cnt_width(N_PLANES);
    localparam int unsigned WD_IX_W = cnt_width(N_WORDS);
    localparam int unsigned RC_W    = cnt_width(N_WORDS + 1);
    localparam int unsigned DOG_W   = cnt_width(RES_TIMEOUT + 1);
    localparam int unsigned DIM_W   = cnt_width(MATRIX_DIM);

    seq_state_t           state;
    logic                 s_ready_r, rd_valid_r, busy_r, done_r, err_r;
    logic [3:0]           we_r;
    logic [WORD_LEN-1:0]  wr_data_r;
    logic [ADDR_BITS-1:0] dir_m1_r, dir_m2_r;
    logic [RC_W-1:0]      res_cnt;
    logic [DOG_W-1:0]     dog_cnt;

    logic [PL_W-1:0]      plane;
    logic [WD_IX_W-1:0]   word;
    logic                 load_last;
    logic [DIM_W-1:0]     row, col;
    logic                 cmp_last;
    logic                 beat, run_clr;

    assign beat    = (state == ST_LOAD) && bus.s_valid;
    assign run_clr = (state == ST_IDLE) && bus.start;

    mat_idx_counter #(.OUTER_N(N_PLANES), .INNER_N(N_WORDS)) u_load_idx (
        .clk(clk), .rst(rst), .clr(run_clr), .en(beat),
        .outer(plane), .inner(word), .last(load_last)
    );

    mat_idx_counter #(.OUTER_N(MATRIX_DIM), .INNER_N(MATRIX_DIM)) u_cmp_idx (
        .clk(clk), .rst(rst), .clr(run_clr), .en(state == ST_COMPUTE),
        .outer(row), .inner(col), .last(cmp_last)
    );

    assign bus.s_ready  = s_ready_r;
    assign bus.we       = we_r;
    assign bus.wr_data  = wr_data_r;
    assign bus.Dir_M1   = dir_m1_r;
    assign bus.Dir_M2   = dir_m2_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.err      = err_r;

    // Sequencer FSM with registered outputs, result counting and drain watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            s_ready_r  <= 1'b0;
            we_r       <= '0;
            wr_data_r  <= '0;
            dir_m1_r   <= '0;
            dir_m2_r   <= '0;
            rd_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            res_cnt    <= '0;
            dog_cnt    <= '0;
        end else begin
            we_r       <= '0;
            done_r     <= 1'b0;
            rd_valid_r <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state     <= ST_LOAD;
                        s_ready_r <= 1'b1;
                        busy_r    <= 1'b1;
                        err_r     <= 1'b0;
                        res_cnt   <= '0;
                        dog_cnt   <= '0;
                    end
                    if (bus.res_valid) err_r <= 1'b1;
                end
                ST_LOAD: begin
                    if (bus.s_valid) begin
                        we_r      <= plane_we(plane);
                        wr_data_r <= bus.s_data;
                        if (plane < PL_W'(2)) begin
                            dir_m1_r <= ADDR_BITS'(word);
                            dir_m2_r <= '0;
                        end else begin
                            dir_m1_r <= '0;
                            dir_m2_r <= ADDR_BITS'(word);
                        end
                        if (load_last) begin
                            state     <= ST_COMPUTE;
                            s_ready_r <= 1'b0;
                        end
                    end
                    if (bus.res_valid) err_r <= 1'b1;
                end
                ST_COMPUTE: begin
                    rd_valid_r <= 1'b1;
                    dir_m1_r   <= ADDR_BITS'(row);
                    dir_m2_r   <= ADDR_BITS'(col);
                    if (cmp_last) state <= ST_DRAIN;
                    if (bus.res_valid) begin
                        dog_cnt <= '0;
                        if (res_cnt == RC_W'(N_WORDS)) err_r <= 1'b1;
                        else res_cnt <= res_cnt + RC_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Finish on the final counted result, on a count already
                    // complete at COMPUTE exit, or on watchdog expiry.
                    if (bus.res_valid) begin
                        dog_cnt <= '0;
                        if (res_cnt == RC_W'(N_WORDS)) begin
                            err_r <= 1'b1;
                        end else begin
                            res_cnt <= res_cnt + RC_W'(1);
                            if (res_cnt == RC_W'(N_WORDS - 1)) begin
                                state     <= ST_IDLE;
                                done_r    <= 1'b1;
                                busy_r    <= 1'b0;
                                dir_m1_r  <= '0;
                                dir_m2_r  <= '0;
                                wr_data_r <= '0;
                            end
                        end
                    end else if (res_cnt == RC_W'(N_WORDS) ||
                                 dog_cnt == DOG_W'(RES_TIMEOUT - 1)) begin
                        if (res_cnt != RC_W'(N_WORDS)) err_r <= 1'b1;
                        state     <= ST_IDLE;
                        done_r    <= 1'b1;
                        busy_r    <= 1'b0;
                        dir_m1_r  <= '0;
                        dir_m2_r  <= '0;
                        wr_data_r <= '0;
                    end else begin
                        dog_cnt <= dog_cnt + DOG_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed, scoreboarded bench for matmul_seq_ctrl.
module tb_matmul_seq_ctrl;

    localparam int unsigned WL  = 16;
    localparam int unsigned DIM = 8;
    localparam int unsigned AB  = 7;
    localparam int unsigned TMO = 255;
    localparam int unsigned NW  = DIM * DIM;

    typedef struct packed {
        logic [3:0]    we;
        logic [AB-1:0] a1;
        logic [AB-1:0] a2;
        logic [WL-1:0] d;
    } wr_rec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matmul_seq_ctrl_if #(.WORD_LEN(WL), .ADDR_BITS(AB)) bus ();

    matmul_seq_ctrl #(
        .WORD_LEN(WL), .MATRIX_DIM(DIM), .ADDR_BITS(AB), .RES_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    wr_rec_t         wq[$];
    logic [2*AB-1:0] pq[$];
    logic [3:0]      we_tab [4] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};

    logic [2:0] hist = '0;
    logic       res_pipe_v = 1'b0;
    logic       stray_res = 1'b0;
    int         res_budget = 0;
    int         rd_run = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         last_res_cyc = 0;
    logic       err_at_done = 1'b0;

    assign bus.res_valid = res_pipe_v | stray_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Datapath model: each issued read returns a result three cycles later
    always @(negedge clk) hist = {hist[1:0], bus.rd_valid};
    always @(posedge clk) begin
        #1;
        if (hist[2] && res_budget > 0) begin
            res_pipe_v = 1'b1;
            res_budget--;
        end else begin
            res_pipe_v = 1'b0;
        end
    end

    // Output monitor: writes and read pairs against the scoreboard queues
    always @(negedge clk) begin
        if (bus.we != 4'b0000) begin
            if (wq.size() == 0) begin
                chk("we_unexpected", {28'd0, bus.we}, 32'd0);
            end else begin
                wr_rec_t e;
                e = wq.pop_front();
                chk("we", {28'd0, bus.we}, {28'd0, e.we});
                chk("wr_Dir_M1", {25'd0, bus.Dir_M1}, {25'd0, e.a1});
                chk("wr_Dir_M2", {25'd0, bus.Dir_M2}, {25'd0, e.a2});
                chk("wr_data", {16'd0, bus.wr_data}, {16'd0, e.d});
            end
        end
        if (bus.rd_valid) begin
            rd_run++;
            if (pq.size() == 0) begin
                chk("rd_unexpected", 32'(bus.rd_valid), 32'd0);
            end else begin
                logic [2*AB-1:0] p;
                p = pq.pop_front();
                chk("rd_pair", {18'd0, bus.Dir_M1, bus.Dir_M2}, {18'd0, p});
            end
        end else if (rd_run != 0) begin
            chk("rd_run_len", rd_run, NW);
            rd_run = 0;
        end
        if (bus.res_valid) last_res_cyc = cyc;
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            err_at_done = bus.err;
            chk("busy_at_done", 32'(bus.busy), 32'd0);
        end
    end

    task automatic start_run();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("start_busy", 32'(bus.busy), 32'd1);
        chk("start_s_ready", 32'(bus.s_ready), 32'd1);
        chk("start_err_clr", 32'(bus.err), 32'd0);
    endtask

    task automatic load_stream(input int unsigned n_beats, input bit gaps, input logic [15:0] xv);
        wr_rec_t r;
        int unsigned pl, wd;
        for (int unsigned k = 0; k < n_beats; k++) begin
            if (gaps) begin
                int unsigned idle;
                idle = $urandom_range(0, 2);
                bus.s_valid = 1'b0;
                repeat (idle) begin @(posedge clk); #1; end
            end
            pl = k / NW;
            wd = k % NW;
            r.we = we_tab[pl];
            r.a1 = (pl < 2) ? AB'(wd) : '0;
            r.a2 = (pl < 2) ? '0 : AB'(wd);
            r.d  = 16'(k) ^ xv;
            wq.push_back(r);
            if (k == 4 * NW - 1) begin
                for (int unsigned i = 0; i < DIM; i++)
                    for (int unsigned j = 0; j < DIM; j++)
                        pq.push_back({AB'(i), AB'(j)});
            end
            if (k == 0 || k == n_beats - 1) chk("s_ready_beat", 32'(bus.s_ready), 32'd1);
            bus.s_valid = 1'b1;
            bus.s_data  = r.d;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input logic exp_err);
        int prev;
        prev = done_cnt;
        for (int n = 0; n < 2000 && done_cnt == prev; n++) begin
            @(posedge clk); #1;
        end
        chk({tag, "_done_seen"}, done_cnt - prev, 1);
        chk({tag, "_done_lat"}, done_cyc - last_res_cyc, exp_lat);
        chk({tag, "_err"}, 32'(err_at_done), 32'(exp_err));
        repeat (5) begin @(posedge clk); #1; end
        chk({tag, "_done_once"}, done_cnt - prev, 1);
        chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cyc=%0d required=finish", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        bus.start   = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_we", {28'd0, bus.we}, 32'd0);
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_addr", {18'd0, bus.Dir_M1, bus.Dir_M2}, 32'd0);
        chk("rst_wr_data", {16'd0, bus.wr_data}, 32'd0);

        // Abort a load after 37 beats
        start_run();
        load_stream(37, 1'b0, 16'h1234);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_we", {28'd0, bus.we}, 32'd0);
        chk("abort_s_ready", 32'(bus.s_ready), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);

        // Full continuous run, all results returned
        res_budget = NW;
        start_run();
        load_stream(4 * NW, 1'b0, 16'h0000);
        chk("load_end_s_ready", 32'(bus.s_ready), 32'd0);
        wait_done("full", 1, 1'b0);

        // Gapped stream, start pulse while computing, then stray result in IDLE
        res_budget = NW;
        start_run();
        load_stream(4 * NW, 1'b1, 16'hA5A5);
        repeat (5) begin @(posedge clk); #1; end
        chk("compute_busy", 32'(bus.busy), 32'd1);
        chk("compute_rd_valid", 32'(bus.rd_valid), 32'd1);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done("gaps", 1, 1'b0);
        stray_res = 1'b1;
        @(posedge clk); #1;
        stray_res = 1'b0;
        chk("stray_err", 32'(bus.err), 32'd1);
        chk("stray_busy", 32'(bus.busy), 32'd0);

        // One result short: watchdog ends the run with err
        res_budget = NW - 1;
        start_run();
        load_stream(4 * NW, 1'b0, 16'hFFFF);
        wait_done("short", TMO + 1, 1'b1);
        chk("short_err_hold", 32'(bus.err), 32'd1);
        start_run();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("final_busy", 32'(bus.busy), 32'd0);
        chk("final_wq_empty", wq.size(), 0);
        chk("final_pq_empty", pq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
